lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load-store unit directly downstream of the ALU: takes o_alu_data as the effective address and
//  performs RISC-V loads/stores against a word-organised data memory and memory-mapped I/O.
//  Stores commit on the rising clock edge. Loads return combinationally in the same cycle, as the
//  single-cycle datapath requires. The load result feeds the write-back mux.
// PARAMETERS
//  DMEM_AW    11   word-address width of data memory (2**11 words = 8 KiB, mapped 0x2000-0x3FFF)
//  SYNC_STG   2    synchronizer flops on i_io_sw / i_io_btn (>=2)
// PORTS
//  i_clk         in   1   clock; all state updates on rising edge
//  i_reset       in   1   reset, asynchronous, active-high
//  i_lsu_addr    in   32  effective address (ALU result)
//  i_st_data     in   32  store data (rs2)
//  i_lsu_wren    in   1   1 = store, 0 = load/no-op
//  i_funct3      in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_io_sw       in   32  switches (asynchronous to i_clk)
//  i_io_btn      in   4   push buttons (asynchronous to i_clk)
//  o_ld_data     out  32  load result, sign/zero-extended
//  o_misaligned  out  1   current access is misaligned or has an illegal funct3
//  o_io_ledr     out  32  red LED register
//  o_io_ledg     out  32  green LED register
//  o_io_hexl     out  32  7-seg digits 0-3 (one byte per digit, bits [6:0] used)
//  o_io_hexh     out  32  7-seg digits 4-7
//  o_io_lcd      out  32  LCD control/data register
// BEHAVIOUR
//  Memory map (addr[31:16] must be 0, otherwise unmapped):
//   0x2000-0x3FFF DMEM, RW | 0x7000 LEDR | 0x7010 LEDG | 0x7020 HEXL | 0x7024 HEXH
//   0x7030 LCD, RW | 0x7800 SW, RO | 0x7810 BTN, RO (zero-extended)
//   Any other address is unmapped.
//  Endianness: little-endian. Byte lane = addr[1:0]. Halfword lane = addr[1].
//  Store: byte-enable mask is derived from funct3 and addr[1:0]. Only the enabled lanes of the
//   target word/register update at the rising edge. Stores to RO or unmapped addresses are dropped.
//  Load: o_ld_data is combinational from the current addr/funct3 and the current state.
//   - B/H results are sign-extended; BU/HU results are zero-extended.
//   - Output registers read back their stored value.
//   - Unmapped addresses read 32'h0.
//   - During a store cycle o_ld_data is don't-care.
//  Read-during-write: a load in the cycle after a store to the same address returns the new data.
//  Misalignment: H/HU with addr[0]=1, W with addr[1:0]!=0, or funct3 in {011,110,111}:
//   - o_misaligned = 1, o_ld_data = 0, and the store (if any) is suppressed.
//   - o_misaligned is combinational and has no effect on state.
//  Inputs: i_io_sw and i_io_btn pass through a SYNC_STG-deep flop chain. A change becomes visible
//   to loads exactly SYNC_STG rising edges later.
//  Reset (asynchronous, independent of clock):
//   - Asserted: all output registers and synchronizer flops go to 0 immediately.
//   - DMEM contents are not reset (undefined until written).
//   - A store coincident with a reset edge is lost.
//   - First store honoured is at the first rising edge after deassertion.
//  DMEM has no side effects on read. Address bits above DMEM_AW+1 within the DMEM window alias per window.
// TESTING
//  1 Reset: assert i_reset mid-cycle -> o_io_ledr/ledg/hexl/hexh/lcd = 0 immediately, before any clock edge.
//  2 Widths: SW 0x2000 = 0x8180_7F01; then:
//    - LB 0x2000 -> 0x0000_0001; LB 0x2003 -> 0xFFFF_FF81; LBU 0x2003 -> 0x0000_0081
//    - LH 0x2002 -> 0xFFFF_8180; LHU 0x2002 -> 0x0000_8180
//  3 Byte stores: SW 0x2004 = 0; SB 0x2005 = 0xAB; SH 0x2006 = 0x1234 -> LW 0x2004 = 0x1234_AB00.
//  4 Misaligned: SW 0x2001 = 0xFFFF_FFFF -> o_misaligned = 1, LW 0x2000 unchanged.
//    LH 0x2003 -> o_ld_data = 0, o_misaligned = 1.
//  5 I/O:
//    - SW 0x7000 = 0x3FF -> o_io_ledr = 0x3FF next edge.
//    - SB 0x7025 = 0x79 -> o_io_hexh = 0x0000_7900.
//    - Store to 0x7800 -> ignored.
//    - Store to 0x9000 -> ignored; LW 0x9000 -> 0.
//  6 Sync: i_io_sw 0 -> 0xA5; LW 0x7800 reads 0 after 1 edge and 0xA5 after 2 edges (SYNC_STG=2).

Source files
------------

// File: rtl/lsu.sv
// Load-store unit: byte/halfword/word loads and stores against a word-organised
// data memory and a small block of memory-mapped I/O registers. Loads are
// combinational; stores commit on the rising clock edge.
module lsu #(
  parameter int DMEM_AW  = 11,
  parameter int SYNC_STG = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_hexl,
  output logic [31:0] o_io_hexh,
  output logic [31:0] o_io_lcd
);

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  localparam logic [15:0] LEDR_A = 16'h7000;
  localparam logic [15:0] LEDG_A = 16'h7010;
  localparam logic [15:0] HEXL_A = 16'h7020;
  localparam logic [15:0] HEXH_A = 16'h7024;
  localparam logic [15:0] LCD_A  = 16'h7030;
  localparam logic [15:0] SW_A   = 16'h7800;
  localparam logic [15:0] BTN_A  = 16'h7810;

  // Overwrite only the byte lanes selected by be.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  // Select the addressed byte/halfword and sign- or zero-extend it.
  function automatic logic [31:0] ld_extend(input logic [31:0] w,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[8*lane +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      F_B:     return {{24{b[7]}}, b};
      F_BU:    return {24'h0, b};
      F_H:     return {{16{h[15]}}, h};
      F_HU:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  logic [31:0] mem [2**DMEM_AW];
  logic [31:0] sw_sync  [SYNC_STG];
  logic [3:0]  btn_sync [SYNC_STG];

  logic              mapped_hi;
  logic [15:2]       wa;
  logic              is_dmem, is_ledr, is_ledg, is_hexl, is_hexh, is_lcd, is_sw, is_btn;
  logic [DMEM_AW-1:0] dmem_idx;
  logic              mis;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              st_ok;
  logic [31:0]       rword;

  assign mapped_hi = (i_lsu_addr[31:16] == 16'h0);
  assign wa        = i_lsu_addr[15:2];
  assign is_dmem   = mapped_hi && (i_lsu_addr[15:13] == 3'b001);
  assign is_ledr   = mapped_hi && (wa == LEDR_A[15:2]);
  assign is_ledg   = mapped_hi && (wa == LEDG_A[15:2]);
  assign is_hexl   = mapped_hi && (wa == HEXL_A[15:2]);
  assign is_hexh   = mapped_hi && (wa == HEXH_A[15:2]);
  assign is_lcd    = mapped_hi && (wa == LCD_A[15:2]);
  assign is_sw     = mapped_hi && (wa == SW_A[15:2]);
  assign is_btn    = mapped_hi && (wa == BTN_A[15:2]);
  assign dmem_idx  = i_lsu_addr[DMEM_AW+1:2];

  // Alignment check, byte-enable mask and lane-replicated store data.
  always_comb begin
    mis   = 1'b0;
    be    = 4'b0000;
    wdata = i_st_data;
    case (i_funct3)
      F_B, F_BU: begin
        be    = 4'b0001 << i_lsu_addr[1:0];
        wdata = {4{i_st_data[7:0]}};
      end
      F_H, F_HU: begin
        mis   = i_lsu_addr[0];
        be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_st_data[15:0]}};
      end
      F_W: begin
        mis = (i_lsu_addr[1:0] != 2'b00);
        be  = 4'b1111;
      end
      default: mis = 1'b1;
    endcase
  end

  assign st_ok        = i_lsu_wren && !mis;
  assign o_misaligned = mis;

  // Data memory write port; contents are never reset, stores during reset are dropped.
  always_ff @(posedge i_clk) begin
    if (st_ok && is_dmem && !i_reset)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[dmem_idx][8*i +: 8] <= wdata[8*i +: 8];
  end

  // Output registers: byte-lane stores, cleared immediately by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_io_ledr <= '0;
      o_io_ledg <= '0;
      o_io_hexl <= '0;
      o_io_hexh <= '0;
      o_io_lcd  <= '0;
    end else if (st_ok) begin
      if (is_ledr) o_io_ledr <= merge_lanes(o_io_ledr, wdata, be);
      if (is_ledg) o_io_ledg <= merge_lanes(o_io_ledg, wdata, be);
      if (is_hexl) o_io_hexl <= merge_lanes(o_io_hexl, wdata, be);
      if (is_hexh) o_io_hexh <= merge_lanes(o_io_hexh, wdata, be);
      if (is_lcd)  o_io_lcd  <= merge_lanes(o_io_lcd,  wdata, be);
    end
  end

  // Synchronizer chains for the asynchronous switch and button inputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STG; i++) begin
        sw_sync[i]  <= '0;
        btn_sync[i] <= '0;
      end
    end else begin
      sw_sync[0]  <= i_io_sw;
      btn_sync[0] <= i_io_btn;
      for (int i = 1; i < SYNC_STG; i++) begin
        sw_sync[i]  <= sw_sync[i-1];
        btn_sync[i] <= btn_sync[i-1];
      end
    end
  end

  // Read mux: pick the addressed word; unmapped addresses read zero.
  always_comb begin
    rword = '0;
    if (is_dmem)      rword = mem[dmem_idx];
    else if (is_ledr) rword = o_io_ledr;
    else if (is_ledg) rword = o_io_ledg;
    else if (is_hexl) rword = o_io_hexl;
    else if (is_hexh) rword = o_io_hexh;
    else if (is_lcd)  rword = o_io_lcd;
    else if (is_sw)   rword = sw_sync[SYNC_STG-1];
    else if (is_btn)  rword = {28'h0, btn_sync[SYNC_STG-1]};
  end

  assign o_ld_data = mis ? 32'h0 : ld_extend(rword, i_funct3, i_lsu_addr[1:0]);

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load-store unit.
module tb_lsu;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic        i_lsu_wren;
  logic [2:0]  i_funct3;
  logic [31:0] i_io_sw;
  logic [3:0]  i_io_btn;
  logic [31:0] o_ld_data;
  logic        o_misaligned;
  logic [31:0] o_io_ledr, o_io_ledg, o_io_hexl, o_io_hexh, o_io_lcd;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  lsu #(.DMEM_AW(11), .SYNC_STG(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_lsu_addr(i_lsu_addr), .i_st_data(i_st_data),
    .i_lsu_wren(i_lsu_wren), .i_funct3(i_funct3), .i_io_sw(i_io_sw), .i_io_btn(i_io_btn),
    .o_ld_data(o_ld_data), .o_misaligned(o_misaligned), .o_io_ledr(o_io_ledr),
    .o_io_ledg(o_io_ledg), .o_io_hexl(o_io_hexl), .o_io_hexh(o_io_hexh), .o_io_lcd(o_io_lcd)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    i_lsu_addr = a; i_st_data = d; i_funct3 = f3; i_lsu_wren = 1'b1;
    @(posedge i_clk); #1;
    i_lsu_wren = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3);
    i_lsu_wren = 1'b0; i_lsu_addr = a; i_funct3 = f3;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge i_clk); i_reset = 1'b1;
    @(negedge i_clk); i_reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_store(32'h7000, 32'h1111_1111, W);
    do_store(32'h7010, 32'h2222_2222, W);
    do_store(32'h7020, 32'h3333_3333, W);
    do_store(32'h7024, 32'h4444_4444, W);
    do_store(32'h7030, 32'h5555_5555, W);
    n_cmp++; if (o_io_ledr !== 32'h1111_1111) begin n_bad++; $display("FAIL pre_reset_ledr got %h exp %h", o_io_ledr, 32'h1111_1111); end
    n_cmp++; if (o_io_lcd !== 32'h5555_5555) begin n_bad++; $display("FAIL pre_reset_lcd got %h exp %h", o_io_lcd, 32'h5555_5555); end
    // assert mid-cycle, check before the next rising edge
    @(negedge i_clk); #2; i_reset = 1'b1; #1;
    n_cmp++; if (o_io_ledr !== 32'h0) begin n_bad++; $display("FAIL async_rst_ledr got %h exp 0", o_io_ledr); end
    n_cmp++; if (o_io_ledg !== 32'h0) begin n_bad++; $display("FAIL async_rst_ledg got %h exp 0", o_io_ledg); end
    n_cmp++; if (o_io_hexl !== 32'h0) begin n_bad++; $display("FAIL async_rst_hexl got %h exp 0", o_io_hexl); end
    n_cmp++; if (o_io_hexh !== 32'h0) begin n_bad++; $display("FAIL async_rst_hexh got %h exp 0", o_io_hexh); end
    n_cmp++; if (o_io_lcd !== 32'h0) begin n_bad++; $display("FAIL async_rst_lcd got %h exp 0", o_io_lcd); end
    // store while reset is held is lost
    do_store(32'h7000, 32'h0000_0055, W);
    n_cmp++; if (o_io_ledr !== 32'h0) begin n_bad++; $display("FAIL store_in_reset got %h exp 0", o_io_ledr); end
    @(negedge i_clk); i_reset = 1'b0;
    do_store(32'h7000, 32'h0000_0077, W);
    n_cmp++; if (o_io_ledr !== 32'h77) begin n_bad++; $display("FAIL first_store_after_reset got %h exp %h", o_io_ledr, 32'h77); end
    pulse_reset();
  endtask

  task automatic test_widths();
    do_store(32'h2000, 32'h8180_7F01, W);
    do_load(32'h2000, W);
    n_cmp++; if (o_ld_data !== 32'h8180_7F01) begin n_bad++; $display("FAIL lw_2000 got %h exp %h", o_ld_data, 32'h8180_7F01); end
    n_cmp++; if (o_misaligned !== 1'b0) begin n_bad++; $display("FAIL lw_aligned_flag got %b exp 0", o_misaligned); end
    do_load(32'h2000, B);
    n_cmp++; if (o_ld_data !== 32'h0000_0001) begin n_bad++; $display("FAIL lb_2000 got %h exp %h", o_ld_data, 32'h1); end
    do_load(32'h2001, B);
    n_cmp++; if (o_ld_data !== 32'h0000_007F) begin n_bad++; $display("FAIL lb_2001 got %h exp %h", o_ld_data, 32'h7F); end
    do_load(32'h2002, B);
    n_cmp++; if (o_ld_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_2002 got %h exp %h", o_ld_data, 32'hFFFF_FF80); end
    do_load(32'h2003, B);
    n_cmp++; if (o_ld_data !== 32'hFFFF_FF81) begin n_bad++; $display("FAIL lb_2003 got %h exp %h", o_ld_data, 32'hFFFF_FF81); end
    do_load(32'h2003, BU);
    n_cmp++; if (o_ld_data !== 32'h0000_0081) begin n_bad++; $display("FAIL lbu_2003 got %h exp %h", o_ld_data, 32'h81); end
    do_load(32'h2000, H);
    n_cmp++; if (o_ld_data !== 32'h0000_7F01) begin n_bad++; $display("FAIL lh_2000 got %h exp %h", o_ld_data, 32'h7F01); end
    do_load(32'h2002, H);
    n_cmp++; if (o_ld_data !== 32'hFFFF_8180) begin n_bad++; $display("FAIL lh_2002 got %h exp %h", o_ld_data, 32'hFFFF_8180); end
    do_load(32'h2002, HU);
    n_cmp++; if (o_ld_data !== 32'h0000_8180) begin n_bad++; $display("FAIL lhu_2002 got %h exp %h", o_ld_data, 32'h8180); end
  endtask

  task automatic test_byte_stores();
    do_store(32'h2004, 32'h0000_0000, W);
    do_store(32'h2005, 32'hFFFF_FFAB, B);
    do_store(32'h2006, 32'hFFFF_1234, H);
    do_load(32'h2004, W);
    n_cmp++; if (o_ld_data !== 32'h1234_AB00) begin n_bad++; $display("FAIL sb_sh_merge got %h exp %h", o_ld_data, 32'h1234_AB00); end
  endtask

  task automatic test_back_to_back();
    do_store(32'h2008, 32'hA0A0_0001, W);
    do_store(32'h200C, 32'hB0B0_0002, W);
    do_load(32'h200C, W);
    n_cmp++; if (o_ld_data !== 32'hB0B0_0002) begin n_bad++; $display("FAIL b2b_second got %h exp %h", o_ld_data, 32'hB0B0_0002); end
    do_load(32'h2008, W);
    n_cmp++; if (o_ld_data !== 32'hA0A0_0001) begin n_bad++; $display("FAIL b2b_first got %h exp %h", o_ld_data, 32'hA0A0_0001); end
  endtask

  task automatic test_misaligned();
    i_lsu_addr = 32'h2001; i_st_data = 32'hFFFF_FFFF; i_funct3 = W; i_lsu_wren = 1'b1; #1;
    n_cmp++; if (o_misaligned !== 1'b1) begin n_bad++; $display("FAIL sw_2001_flag got %b exp 1", o_misaligned); end
    @(posedge i_clk); #1; i_lsu_wren = 1'b0;
    do_load(32'h2000, W);
    n_cmp++; if (o_ld_data !== 32'h8180_7F01) begin n_bad++; $display("FAIL sw_2001_suppressed got %h exp %h", o_ld_data, 32'h8180_7F01); end
    do_load(32'h2003, H);
    n_cmp++; if (o_ld_data !== 32'h0) begin n_bad++; $display("FAIL lh_2003_data got %h exp 0", o_ld_data); end
    n_cmp++; if (o_misaligned !== 1'b1) begin n_bad++; $display("FAIL lh_2003_flag got %b exp 1", o_misaligned); end
    do_load(32'h2000, 3'b011);
    n_cmp++; if (o_misaligned !== 1'b1) begin n_bad++; $display("FAIL f3_011_flag got %b exp 1", o_misaligned); end
    n_cmp++; if (o_ld_data !== 32'h0) begin n_bad++; $display("FAIL f3_011_data got %h exp 0", o_ld_data); end
  endtask

  task automatic test_sync();
    i_io_sw = 32'hA5; i_io_btn = 4'hC;
    do_load(32'h7800, W);
    n_cmp++; if (o_ld_data !== 32'h0) begin n_bad++; $display("FAIL sw_0_edges got %h exp 0", o_ld_data); end
    @(posedge i_clk); #1;
    n_cmp++; if (o_ld_data !== 32'h0) begin n_bad++; $display("FAIL sw_1_edge got %h exp 0", o_ld_data); end
    @(posedge i_clk); #1;
    n_cmp++; if (o_ld_data !== 32'hA5) begin n_bad++; $display("FAIL sw_2_edges got %h exp %h", o_ld_data, 32'hA5); end
    do_load(32'h7810, W);
    n_cmp++; if (o_ld_data !== 32'hC) begin n_bad++; $display("FAIL btn_2_edges got %h exp %h", o_ld_data, 32'hC); end
  endtask

  task automatic test_io();
    i_lsu_addr = 32'h7000; i_st_data = 32'h3FF; i_funct3 = W; i_lsu_wren = 1'b1; #1;
    n_cmp++; if (o_io_ledr !== 32'h0) begin n_bad++; $display("FAIL ledr_before_edge got %h exp 0", o_io_ledr); end
    @(posedge i_clk); #1; i_lsu_wren = 1'b0;
    n_cmp++; if (o_io_ledr !== 32'h3FF) begin n_bad++; $display("FAIL ledr_after_edge got %h exp %h", o_io_ledr, 32'h3FF); end
    do_store(32'h7025, 32'h79, B);
    n_cmp++; if (o_io_hexh !== 32'h0000_7900) begin n_bad++; $display("FAIL hexh_sb got %h exp %h", o_io_hexh, 32'h7900); end
    n_cmp++; if (o_io_hexl !== 32'h0) begin n_bad++; $display("FAIL hexl_untouched got %h exp 0", o_io_hexl); end
    do_store(32'h7030, 32'hCAFE_1234, W);
    do_load(32'h7032, H);
    n_cmp++; if (o_ld_data !== 32'hFFFF_CAFE) begin n_bad++; $display("FAIL lcd_lh got %h exp %h", o_ld_data, 32'hFFFF_CAFE); end
    do_load(32'h7025, BU);
    n_cmp++; if (o_ld_data !== 32'h79) begin n_bad++; $display("FAIL hexh_lbu got %h exp %h", o_ld_data, 32'h79); end
    do_store(32'h7800, 32'hFFFF_FFFF, W);
    do_load(32'h7800, W);
    n_cmp++; if (o_ld_data !== 32'hA5) begin n_bad++; $display("FAIL sw_ro got %h exp %h", o_ld_data, 32'hA5); end
    do_store(32'h9000, 32'h1234_5678, W);
    do_load(32'h9000, W);
    n_cmp++; if (o_ld_data !== 32'h0) begin n_bad++; $display("FAIL unmapped_9000 got %h exp 0", o_ld_data); end
    do_store(32'h0001_2000, 32'h0000_0055, W);
    do_load(32'h0001_2000, W);
    n_cmp++; if (o_ld_data !== 32'h0) begin n_bad++; $display("FAIL unmapped_12000 got %h exp 0", o_ld_data); end
    do_load(32'h2000, W);
    n_cmp++; if (o_ld_data !== 32'h8180_7F01) begin n_bad++; $display("FAIL dmem_not_hit got %h exp %h", o_ld_data, 32'h8180_7F01); end
    n_cmp++; if (o_io_ledr !== 32'h3FF) begin n_bad++; $display("FAIL ledr_kept got %h exp %h", o_io_ledr, 32'h3FF); end
  endtask

  initial begin
    i_reset = 1'b1; i_lsu_addr = '0; i_st_data = '0; i_lsu_wren = 1'b0;
    i_funct3 = W; i_io_sw = '0; i_io_btn = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); i_reset = 1'b0; #1;
    test_reset();
    test_widths();
    test_byte_stores();
    test_back_to_back();
    test_misaligned();
    test_sync();
    test_io();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
